layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Parametrised successor to the top-level display mixer. Merges NUM_LAYERS pre-rendered 12-bit
//  layer pixels (waveform, menubars, error box, sprites) by fixed priority instead of additive
//  summing, so overlapping layers no longer overflow. Adds an internal boot progress-bar layer and a
//  status FSM that applies per-state layer masks and PAUSE dimming on frame boundaries only.
//  Sits between the layer generators and the VGA RGB pins, in the 65 MHz pixel domain.
// PARAMETERS
//  NUM_LAYERS   4        external layers; index 0 = highest priority
//  BG_COLOR     12'h000  background when no layer is visible
//  RUN_MASK     4'b1111  layer enable mask in RUN (bit i = layer i)
//  PAUSE_MASK   4'b1111  layer enable mask in PAUSE
//  ERROR_MASK   4'b1110  layer enable mask in ERROR
//  BOOT_TICKS   262144   clk cycles per progress-bar increment
//  PB_MAX       1024     final progress-bar width in pixels
//  PB_Y         374      progress-bar top row; bar height is 20 rows
//  ERR_LAYER    1        layer index that blinks in ERROR (COMPOSITOR_BLINK_EN only)
//  BLINK_FRAMES 32       frames per blink half-period
// PORTS
//  clk_65mhz        in   1              pixel clock
//  reset_n          in   1              async, active-low reset
//  hcount           in   11             current pixel column
//  vcount           in   10             current pixel row
//  at_display_area  in   1              high inside the visible area
//  system_status    in   3              0=pause, 1=run, 2=error, 3=boot
//  layer_pixel      in   12*NUM_LAYERS  layer i occupies bits [12*i+11:12*i]
//  layer_valid      in   NUM_LAYERS     bit i high = layer i covers this pixel
//  r_out/g_out/b_out out 4 each         composited colour, registered
//  progress_width   out  11             current progress-bar width
//  boot_done        out  1              high once progress_width == PB_MAX
// BEHAVIOUR
//  Reset: r/g/b_out=0, progress_width=0, boot_done=0, tick counter=0, state=BOOT,
//    pipeline valid bits cleared. Reset mid-frame: outputs go to 0 immediately (async).
//  FSM states: BOOT, RUN, PAUSE, ERROR.
//  Frame boundary: the cycle where hcount==0 && vcount==0. State is updated only on this cycle.
//  Transitions out of BOOT: only when boot_done=1 and system_status!=3.
//    status 0 -> PAUSE, 1 -> RUN, 2 -> ERROR.
//  Transitions from RUN/PAUSE/ERROR:
//    status 3 -> BOOT; progress_width, tick counter and boot_done are cleared on entry.
//    Other status codes move directly to the matching state; codes 4-7 hold the current state.
//  BOOT progress bar:
//    - tick counter counts 0..BOOT_TICKS-1 and wraps.
//    - On wrap, if progress_width<PB_MAX, progress_width +1; it saturates at PB_MAX.
//    - boot_done asserts the cycle after progress_width reaches PB_MAX.
//    - In BOOT the bar is the only layer: white (12'hFFF) where hcount<progress_width and
//      PB_Y<=vcount<PB_Y+20; BG_COLOR elsewhere.
//  Layer mask: RUN/PAUSE/ERROR apply RUN_MASK/PAUSE_MASK/ERROR_MASK; BOOT masks all external layers.
//  Stage 1 (registered): select the lowest index i with layer_valid[i] & mask[i]; the selected
//    colour is layer_pixel[i], or BG_COLOR if none. at_display_area is delayed alongside.
//  Stage 2 (registered): in PAUSE each 4-bit channel is shifted right by 1. Output is 0 when the
//    delayed at_display_area is low.
//  Latency: 2 clocks, hcount/vcount/at_display_area -> r/g/b_out. Throughput: 1 pixel per clock.
//  Arithmetic: no addition on colour paths, so overflow cannot occur. progress_width is 11 bits
//    and PB_MAX must be <=2047.
//  A status change arriving mid-frame takes effect at the next frame boundary; a status change
//    on the boundary cycle itself takes effect on that boundary.
// CONFIGURATION
//  COMPOSITOR_BLINK_EN defined:
//    - In ERROR a frame counter toggles a blink phase every BLINK_FRAMES frames.
//    - Layer ERR_LAYER is masked off during the low phase.
//    - Phase and frame counter reset to visible/0 on ERROR entry.
//  COMPOSITOR_BLINK_EN undefined: ERR_LAYER is shown steadily per ERROR_MASK; no counter logic.
// TESTING
//  1. Release reset, system_status=3, BOOT_TICKS=4, PB_MAX=8 -> progress_width steps +1 every
//     4 clks, stops at 8; boot_done goes high 1 clk later. Pixel (3,380) = FFF, (9,380) = 000.
//  2. Status=1 after boot_done; layer 0=F22 and layer 2=17A both valid -> F,2,2 appears
//     2 clks after hcount/vcount; layer 2 alone -> 1,7,A.
//  3. Status=0 mid-frame with layer 0=FFF -> output stays F,F,F until the next frame boundary,
//     then becomes 7,7,7.
//  4. Status=2, ERROR_MASK=1110, only layer 0 valid -> output = BG_COLOR; at_display_area=0
//     -> output 0,0,0.
//  5. Assert reset_n=0 mid-line while in RUN -> r/g/b_out=0 immediately; after release the
//     state is BOOT with progress_width=0.
//  6. COMPOSITOR_BLINK_EN defined, ERROR, BLINK_FRAMES=2, ERR_LAYER valid at F22 -> visible for
//     2 frames, BG for 2 frames, repeating.

Source files
------------

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : layer_compositor
// Purpose  : Priority compositor for NUM_LAYERS pre-rendered 12-bit layers in
//            the 65 MHz pixel domain. Adds an internal boot progress bar and a
//            status FSM (BOOT/RUN/PAUSE/ERROR) that switches layer masks and
//            PAUSE dimming on frame boundaries only. Two-stage pipeline.
// Ports    : clk_65mhz, reset_n (async, active-low)
//            hcount[10:0], vcount[9:0], at_display_area   - pixel position
//            system_status[2:0]  0=pause 1=run 2=error 3=boot
//            layer_pixel[12*NUM_LAYERS-1:0], layer_valid[NUM_LAYERS-1:0]
//            r_out/g_out/b_out[3:0]  registered composited colour
//            progress_width[10:0], boot_done
// Options  : COMPOSITOR_BLINK_EN - blink layer ERR_LAYER in ERROR every
//            BLINK_FRAMES frames (default build: steady ERROR_MASK).
// Revision : 1.0 - initial release
// ============================================================================
module layer_compositor #(
  parameter int                    NUM_LAYERS   = 4,
  parameter logic [11:0]           BG_COLOR     = 12'h000,
  parameter logic [NUM_LAYERS-1:0] RUN_MASK     = 4'b1111,
  parameter logic [NUM_LAYERS-1:0] PAUSE_MASK   = 4'b1111,
  parameter logic [NUM_LAYERS-1:0] ERROR_MASK   = 4'b1110,
  parameter int                    BOOT_TICKS   = 262144,
  parameter int                    PB_MAX       = 1024,
  parameter int                    PB_Y         = 374,
  parameter int                    ERR_LAYER    = 1,
  parameter int                    BLINK_FRAMES = 32
) (
  input  logic                         clk_65mhz,
  input  logic                         reset_n,
  input  logic [10:0]                  hcount,
  input  logic [9:0]                   vcount,
  input  logic                         at_display_area,
  input  logic [2:0]                   system_status,
  input  logic [12*NUM_LAYERS-1:0]     layer_pixel,
  input  logic [NUM_LAYERS-1:0]        layer_valid,
  output logic [3:0]                   r_out,
  output logic [3:0]                   g_out,
  output logic [3:0]                   b_out,
  output logic [10:0]                  progress_width,
  output logic                         boot_done
);

  localparam int          c_tick_w     = (BOOT_TICKS > 1) ? $clog2(BOOT_TICKS) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(BOOT_TICKS - 1);
  localparam logic [10:0] c_pb_max     = 11'(PB_MAX);
  localparam logic [9:0]  c_pb_y       = 10'(PB_Y);
  localparam logic [9:0]  c_pb_y_end   = 10'(PB_Y + 20);
  localparam logic [11:0] c_bar_color  = 12'hFFF;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_frame_start;
  logic                  w_enter_boot;
  logic [c_tick_w-1:0]   r_tick;
  logic                  w_blink_hide;
  logic [NUM_LAYERS-1:0] w_mask;
  logic [11:0]           w_sel_color;
  logic [11:0]           w_s1_color;
  logic [10:0]           w_bar_width;
  logic                  w_in_bar;
  logic [11:0]           r_s1_color;
  logic                  r_s1_de;
  logic                  r_s1_dim;

  assign w_frame_start = (hcount == 11'd0) && (vcount == 10'd0);
  assign w_enter_boot  = (w_state_next == ST_BOOT) && (r_state != ST_BOOT);

  // --------------------------------------------------------------------------
  // Status FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state; only the frame-boundary cycle may change it.
  always_comb begin
    w_state_next = r_state;
    if (w_frame_start) begin
      if (r_state == ST_BOOT) begin
        if (boot_done) begin
          case (system_status)
            3'd0:    w_state_next = ST_PAUSE;
            3'd1:    w_state_next = ST_RUN;
            3'd2:    w_state_next = ST_ERROR;
            default: w_state_next = r_state;
          endcase
        end
      end else begin
        case (system_status)
          3'd0:    w_state_next = ST_PAUSE;
          3'd1:    w_state_next = ST_RUN;
          3'd2:    w_state_next = ST_ERROR;
          3'd3:    w_state_next = ST_BOOT;
          default: w_state_next = r_state;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Boot progress bar: tick prescaler, saturating width, done flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_tick         <= '0;
      progress_width <= 11'd0;
      boot_done      <= 1'b0;
    end else if (w_enter_boot) begin
      r_tick         <= '0;
      progress_width <= 11'd0;
      boot_done      <= 1'b0;
    end else if (r_state == ST_BOOT) begin
      if (r_tick == c_tick_last) begin
        r_tick <= '0;
        if (progress_width < c_pb_max) begin
          progress_width <= progress_width + 11'd1;
        end
      end else begin
        r_tick <= r_tick + c_tick_w'(1);
      end
      // Registered compare gives the one-cycle lag after saturation.
      boot_done <= (progress_width == c_pb_max);
    end
  end

`ifdef COMPOSITOR_BLINK_EN
  // --------------------------------------------------------------------------
  // ERROR blink: frame counter toggles the visible phase of ERR_LAYER
  // --------------------------------------------------------------------------
  localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);

  logic                 r_blink_visible;
  logic                 w_blink_visible_next;
  logic [c_blink_w-1:0] r_frame_cnt;
  logic [c_blink_w-1:0] w_frame_cnt_next;

  always_comb begin
    w_blink_visible_next = r_blink_visible;
    w_frame_cnt_next     = r_frame_cnt;
    if ((w_state_next == ST_ERROR) && (r_state != ST_ERROR)) begin
      w_blink_visible_next = 1'b1;
      w_frame_cnt_next     = '0;
    end else if (w_frame_start && (r_state == ST_ERROR)) begin
      if (r_frame_cnt == c_blink_last) begin
        w_frame_cnt_next     = '0;
        w_blink_visible_next = ~r_blink_visible;
      end else begin
        w_frame_cnt_next = r_frame_cnt + c_blink_w'(1);
      end
    end
  end

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_visible <= 1'b1;
      r_frame_cnt     <= '0;
    end else begin
      r_blink_visible <= w_blink_visible_next;
      r_frame_cnt     <= w_frame_cnt_next;
    end
  end

  // Next-state values so the boundary pixel already sees the new phase.
  assign w_blink_hide = (w_state_next == ST_ERROR) && !w_blink_visible_next;
`else
  assign w_blink_hide = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Stage 1: mask + priority select. Uses the next state so that a status
  // change on the boundary cycle applies to that boundary pixel.
  // --------------------------------------------------------------------------
  always_comb begin
    case (w_state_next)
      ST_RUN:   w_mask = RUN_MASK;
      ST_PAUSE: w_mask = PAUSE_MASK;
      ST_ERROR: w_mask = ERROR_MASK;
      default:  w_mask = '0;
    endcase
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if ((i == ERR_LAYER) && w_blink_hide) begin
        w_mask[i] = 1'b0;
      end
    end
  end

  // Walk from lowest priority up so the lowest valid index wins.
  always_comb begin
    w_sel_color = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i] && w_mask[i]) begin
        w_sel_color = layer_pixel[12*i +: 12];
      end
    end
  end

  // On BOOT entry the width register clears one cycle late; hide it here.
  assign w_bar_width = w_enter_boot ? 11'd0 : progress_width;
  assign w_in_bar    = (vcount >= c_pb_y) && (vcount < c_pb_y_end) &&
                       (hcount < w_bar_width);
  assign w_s1_color  = (w_state_next == ST_BOOT) ?
                       (w_in_bar ? c_bar_color : BG_COLOR) : w_sel_color;

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_color <= 12'h000;
      r_s1_de    <= 1'b0;
      r_s1_dim   <= 1'b0;
    end else begin
      r_s1_color <= w_s1_color;
      r_s1_de    <= at_display_area;
      r_s1_dim   <= (w_state_next == ST_PAUSE);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: PAUSE dimming and display-area blanking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= 4'h0;
      g_out <= 4'h0;
      b_out <= 4'h0;
    end else if (!r_s1_de) begin
      r_out <= 4'h0;
      g_out <= 4'h0;
      b_out <= 4'h0;
    end else if (r_s1_dim) begin
      r_out <= {1'b0, r_s1_color[11:9]};
      g_out <= {1'b0, r_s1_color[7:5]};
      b_out <= {1'b0, r_s1_color[3:1]};
    end else begin
      r_out <= r_s1_color[11:8];
      g_out <= r_s1_color[7:4];
      b_out <= r_s1_color[3:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_compositor
// Purpose  : Directed self-checking bench for layer_compositor
//            (BOOT_TICKS=4, PB_MAX=8, other parameters default).
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

  logic        clk_65mhz = 1'b0;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        at_display_area;
  logic [2:0]  system_status;
  logic [47:0] layer_pixel;
  logic [3:0]  layer_valid;
  logic [3:0]  r_out;
  logic [3:0]  g_out;
  logic [3:0]  b_out;
  logic [10:0] progress_width;
  logic        boot_done;

  int checks = 0;
  int errors = 0;

  layer_compositor #(
    .BOOT_TICKS (4),
    .PB_MAX     (8)
  ) dut (
    .clk_65mhz       (clk_65mhz),
    .reset_n         (reset_n),
    .hcount          (hcount),
    .vcount          (vcount),
    .at_display_area (at_display_area),
    .system_status   (system_status),
    .layer_pixel     (layer_pixel),
    .layer_valid     (layer_valid),
    .r_out           (r_out),
    .g_out           (g_out),
    .b_out           (b_out),
    .progress_width  (progress_width),
    .boot_done       (boot_done)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_65mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rgb();
    return {r_out, g_out, b_out};
  endfunction

  task automatic set_layer(input int i, input logic [11:0] c, input logic v);
    layer_pixel[12*i +: 12] = c;
    layer_valid[i]          = v;
  endtask

  task automatic pix(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
  endtask

  // Presents the frame-boundary pixel for one clock, then moves to (1,0).
  task automatic boundary();
    pix(0, 0);
    step(1);
    pix(1, 0);
  endtask

  initial begin
    reset_n         = 1'b0;
    system_status   = 3'd3;
    at_display_area = 1'b1;
    layer_pixel     = '0;
    layer_valid     = '0;
    pix(100, 100);
    step(3);
    check("reset_rgb", rgb(), 12'h000);
    check("reset_progress", {1'b0, progress_width}, 12'd0);
    check("reset_boot_done", {11'd0, boot_done}, 12'd0);

    // ---- Boot progress bar ----
    reset_n = 1'b1;
    step(4);
    check("progress_after_4", {1'b0, progress_width}, 12'd1);
    step(4);
    check("progress_after_8", {1'b0, progress_width}, 12'd2);
    step(24);
    check("progress_at_max", {1'b0, progress_width}, 12'd8);
    check("boot_done_not_yet", {11'd0, boot_done}, 12'd0);
    step(1);
    check("boot_done_set", {11'd0, boot_done}, 12'd1);
    step(8);
    check("progress_saturates", {1'b0, progress_width}, 12'd8);

    pix(3, 380);   step(2); check("bar_3_380", rgb(), 12'hFFF);
    pix(9, 380);   step(2); check("bar_9_380", rgb(), 12'h000);
    pix(7, 380);   step(2); check("bar_last_col", rgb(), 12'hFFF);
    pix(8, 380);   step(2); check("bar_past_col", rgb(), 12'h000);
    pix(3, 373);   step(2); check("bar_above", rgb(), 12'h000);
    pix(3, 393);   step(2); check("bar_last_row", rgb(), 12'hFFF);
    pix(3, 394);   step(2); check("bar_below", rgb(), 12'h000);
    set_layer(0, 12'hF22, 1'b1);
    pix(9, 380);   step(2); check("boot_masks_layers", rgb(), 12'h000);

    // ---- RUN: status changes only at the frame boundary ----
    system_status = 3'd1;
    pix(9, 100);   step(2); check("run_waits_boundary", rgb(), 12'h000);
    set_layer(2, 12'h17A, 1'b1);
    boundary();    step(2); check("run_prio_0_over_2", rgb(), 12'hF22);
    set_layer(0, 12'hF22, 1'b0);
    step(2);       check("run_layer2_alone", rgb(), 12'h17A);
    set_layer(2, 12'h17A, 1'b0);
    set_layer(1, 12'h0A5, 1'b1);
    set_layer(3, 12'h333, 1'b1);
    step(2);       check("run_prio_1_over_3", rgb(), 12'h0A5);
    set_layer(1, 12'h0A5, 1'b0);
    step(2);       check("run_layer3_alone", rgb(), 12'h333);
    set_layer(3, 12'h333, 1'b0);
    step(2);       check("run_none_bg", rgb(), 12'h000);

    // ---- PAUSE: mid-frame change deferred, then dimmed ----
    set_layer(0, 12'hFFF, 1'b1);
    system_status = 3'd0;
    pix(5, 200);   step(2); check("pause_deferred", rgb(), 12'hFFF);
    step(5);       check("pause_still_deferred", rgb(), 12'hFFF);
    boundary();    step(2); check("pause_dim_fff", rgb(), 12'h777);
    set_layer(0, 12'hF22, 1'b1);
    step(2);       check("pause_dim_f22", rgb(), 12'h711);

    // ---- ERROR: layer 0 masked ----
    system_status = 3'd2;
    pix(5, 200);   step(2); check("error_deferred", rgb(), 12'h711);
    boundary();    step(2); check("error_layer0_masked", rgb(), 12'h000);
    set_layer(1, 12'h5A3, 1'b1);
    step(2);       check("error_layer1_shown", rgb(), 12'h5A3);
    at_display_area = 1'b0;
    step(2);       check("blank_outside_area", rgb(), 12'h000);
    at_display_area = 1'b1;
    system_status = 3'd5;
    boundary();    step(2); check("code5_holds_error", rgb(), 12'h5A3);

    // ---- ERROR -> BOOT clears the bar ----
    system_status = 3'd3;
    boundary();
    check("reboot_progress_clr", {1'b0, progress_width}, 12'd0);
    check("reboot_done_clr", {11'd0, boot_done}, 12'd0);
    step(2);       check("reboot_masks", rgb(), 12'h000);
    for (int k = 0; k < 60 && !boot_done; k++) step(1);
    check("reboot_done_in_time", {11'd0, boot_done}, 12'd1);

    // ---- RUN then async reset mid-line ----
    system_status = 3'd1;
    boundary();
    pix(300, 50);  step(2); check("run_again", rgb(), 12'hF22);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_rgb", rgb(), 12'h000);
    check("async_reset_progress", {1'b0, progress_width}, 12'd0);
    check("async_reset_done", {11'd0, boot_done}, 12'd0);
    step(2);
    reset_n = 1'b1;
    step(2);       check("post_reset_boot", rgb(), 12'h000);
    step(2);       check("post_reset_progress", {1'b0, progress_width}, 12'd1);
    boundary();    step(2); check("boot_no_exit_early", rgb(), 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
